// File: rtl/shadow_stack_arbiter.sv
// rtl/shadow_stack_arbiter.sv - shadow-stack RAM arbiter for the return-address monitor
// Serialises monitor push/pop, pending-command slot and idle-time debug reads onto one sync RAM port.
module shadow_stack_arbiter #(
  parameter int DEPTH_LOG2 = 6,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  mon_en,
  input  logic                  mon_push,
  input  logic [DATA_W-1:0]     mon_wdata,
  output logic [DATA_W-1:0]     mon_rdata,
  output logic                  mon_rvalid,
  input  logic                  dbg_req,
  input  logic [DEPTH_LOG2-1:0] dbg_idx,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  dbg_ack,
  output logic                  dbg_err,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [DEPTH_LOG2-1:0] ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic [DEPTH_LOG2:0]   sp,
  output logic                  ovf,
  output logic                  unf,
  output logic                  drop
);

  localparam logic [DEPTH_LOG2:0] SP_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] SP_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, POP_RD, POP_DONE, DBG_RD, DBG_DONE} state_t;

  state_t state, state_nx;

  logic                  mon_en_q;
  logic                  pend_valid, pend_push;
  logic [DATA_W-1:0]     pend_data;

  logic                  cmd_new, exec_valid, exec_push, dbg_go, dbg_hit;
  logic                  sp_full, sp_empty;
  logic [DATA_W-1:0]     exec_data;
  logic [DEPTH_LOG2:0]   sp_dec, dbg_pos;

  logic                  ram_en_nx, ram_we_nx;
  logic [DEPTH_LOG2-1:0] ram_addr_nx;
  logic [DATA_W-1:0]     ram_wdata_nx, mon_rdata_nx, dbg_rdata_nx, pend_data_nx;
  logic [DEPTH_LOG2:0]   sp_nx;
  logic                  ovf_nx, unf_nx, drop_nx;
  logic                  mon_rvalid_nx, dbg_ack_nx, dbg_err_nx;
  logic                  pend_valid_nx, pend_push_nx;

  // A command is the rising edge of mon_en; a held level issues nothing more.
  assign cmd_new    = mon_en && !mon_en_q;
  assign sp_full    = (sp == SP_FULL);
  assign sp_empty   = (sp == '0);
  assign exec_valid = (state == IDLE) && !clr && (pend_valid || cmd_new);
  assign exec_push  = pend_valid ? pend_push : mon_push;
  assign exec_data  = pend_valid ? pend_data : mon_wdata;
  assign dbg_go     = (state == IDLE) && !clr && !pend_valid && !cmd_new && dbg_req;
  assign dbg_hit    = ({1'b0, dbg_idx} < sp);
  assign sp_dec     = sp - SP_ONE;
  assign dbg_pos    = sp_dec - {1'b0, dbg_idx};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (exec_valid && !exec_push && !sp_empty) state_nx = POP_RD;
        else if (dbg_go && dbg_hit)                state_nx = DBG_RD;
      end
      POP_RD:   state_nx = POP_DONE;
      POP_DONE: state_nx = IDLE;
      DBG_RD:   state_nx = DBG_DONE;
      DBG_DONE: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    ram_en_nx     = 1'b0;
    ram_we_nx     = 1'b0;
    ram_addr_nx   = ram_addr;
    ram_wdata_nx  = ram_wdata;
    sp_nx         = sp;
    ovf_nx        = ovf;
    unf_nx        = unf;
    drop_nx       = drop;
    mon_rdata_nx  = mon_rdata;
    mon_rvalid_nx = 1'b0;
    dbg_rdata_nx  = dbg_rdata;
    dbg_ack_nx    = 1'b0;
    dbg_err_nx    = 1'b0;
    pend_valid_nx = (state == IDLE) ? 1'b0 : pend_valid;
    pend_push_nx  = pend_push;
    pend_data_nx  = pend_data;

    case (state)
      IDLE: begin
        if (exec_valid) begin
          if (exec_push) begin
            if (!sp_full) begin
              ram_en_nx    = 1'b1;
              ram_we_nx    = 1'b1;
              ram_addr_nx  = sp[DEPTH_LOG2-1:0];
              ram_wdata_nx = exec_data;
              sp_nx        = sp + SP_ONE;
            end else begin
              ovf_nx = 1'b1;
            end
          end else if (!sp_empty) begin
            ram_en_nx   = 1'b1;
            ram_addr_nx = sp_dec[DEPTH_LOG2-1:0];
            sp_nx       = sp_dec;
          end else begin
            // A zero return address guarantees the monitor's compare fails.
            unf_nx        = 1'b1;
            mon_rdata_nx  = '0;
            mon_rvalid_nx = 1'b1;
          end
        end else if (dbg_go) begin
          if (dbg_hit) begin
            ram_en_nx   = 1'b1;
            ram_addr_nx = dbg_pos[DEPTH_LOG2-1:0];
          end else begin
            dbg_ack_nx   = 1'b1;
            dbg_err_nx   = 1'b1;
            dbg_rdata_nx = '0;
          end
        end
      end
      POP_DONE: begin
        mon_rdata_nx  = ram_rdata;
        mon_rvalid_nx = 1'b1;
      end
      DBG_DONE: begin
        dbg_rdata_nx = ram_rdata;
        dbg_ack_nx   = 1'b1;
      end
      default: ;
    endcase

    // Commands arriving while busy (or while the slot drains) park in the one-entry slot.
    if (cmd_new && !clr && ((state != IDLE) || pend_valid)) begin
      if ((state != IDLE) && pend_valid) begin
        drop_nx = 1'b1;
      end else begin
        pend_valid_nx = 1'b1;
        pend_push_nx  = mon_push;
        pend_data_nx  = mon_wdata;
      end
    end

    if (clr) begin
      sp_nx         = '0;
      ovf_nx        = 1'b0;
      unf_nx        = 1'b0;
      drop_nx       = 1'b0;
      pend_valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mon_en_q   <= 1'b0;
      pend_valid <= 1'b0;
      pend_push  <= 1'b0;
      pend_data  <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      sp         <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      drop       <= 1'b0;
      mon_rdata  <= '0;
      mon_rvalid <= 1'b0;
      dbg_rdata  <= '0;
      dbg_ack    <= 1'b0;
      dbg_err    <= 1'b0;
    end else begin
      mon_en_q   <= mon_en;
      pend_valid <= pend_valid_nx;
      pend_push  <= pend_push_nx;
      pend_data  <= pend_data_nx;
      ram_en     <= ram_en_nx;
      ram_we     <= ram_we_nx;
      ram_addr   <= ram_addr_nx;
      ram_wdata  <= ram_wdata_nx;
      sp         <= sp_nx;
      ovf        <= ovf_nx;
      unf        <= unf_nx;
      drop       <= drop_nx;
      mon_rdata  <= mon_rdata_nx;
      mon_rvalid <= mon_rvalid_nx;
      dbg_rdata  <= dbg_rdata_nx;
      dbg_ack    <= dbg_ack_nx;
      dbg_err    <= dbg_err_nx;
    end
  end

endmodule

// File: tb/tb_shadow_stack_arbiter.sv
// tb/tb_shadow_stack_arbiter.sv - scoreboard bench for shadow_stack_arbiter
// Small 4-entry stack with a behavioural sync RAM; expected responses are queued with their due cycle.
module tb_shadow_stack_arbiter;
  localparam int DL = 2;
  localparam int DW = 32;

  logic          clk, reset, clr, mon_en, mon_push;
  logic [DW-1:0] mon_wdata, mon_rdata, dbg_rdata, ram_wdata, ram_rdata;
  logic          mon_rvalid, dbg_req, dbg_ack, dbg_err, ram_en, ram_we, ovf, unf, drop;
  logic [DL-1:0] dbg_idx, ram_addr;
  logic [DL:0]   sp;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            due;
  } exp_t;

  exp_t mon_q[$];
  exp_t dbg_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int en_cnt = 0;
  int we_cnt = 0;
  int rv_cnt = 0;
  int snap;
  logic [DW-1:0] mem [0:(1<<DL)-1];

  shadow_stack_arbiter #(.DEPTH_LOG2(DL), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .mon_en(mon_en), .mon_push(mon_push), .mon_wdata(mon_wdata),
    .mon_rdata(mon_rdata), .mon_rvalid(mon_rvalid),
    .dbg_req(dbg_req), .dbg_idx(dbg_idx), .dbg_rdata(dbg_rdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .sp(sp), .ovf(ovf), .unf(unf), .drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ram_en) en_cnt++;
    if (ram_en && ram_we) we_cnt++;
    if (mon_rvalid) begin
      rv_cnt++;
      if (mon_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL mon_unexpected_rvalid: got rvalid with data %0h at cycle %0d, required none", mon_rdata, cyc);
      end else begin
        e = mon_q.pop_front();
        check("mon_rdata", mon_rdata, e.data);
        check("mon_rvalid_cycle", cyc, e.due);
      end
    end
    if (dbg_ack) begin
      if (dbg_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dbg_unexpected_ack: got ack at cycle %0d, required none", cyc);
      end else begin
        e = dbg_q.pop_front();
        check("dbg_rdata", dbg_rdata, e.data);
        check("dbg_err", 32'(dbg_err), 32'(e.err));
        check("dbg_ack_cycle", cyc, e.due);
      end
    end
  end

  // One monitor command: mon_en high for one edge, low for one edge, then gap idle cycles.
  task automatic cmd(input logic push, input logic [DW-1:0] data, input logic exp_rd,
                     input logic [DW-1:0] exp_data, input int lat, input int gap);
    mon_en    = 1'b1;
    mon_push  = push;
    mon_wdata = data;
    if (exp_rd) mon_q.push_back('{exp_data, 1'b0, cyc + 1 + lat});
    @(negedge clk);
    mon_en = 1'b0;
    @(negedge clk);
    repeat (gap) @(negedge clk);
  endtask

  task automatic dbg(input logic [DL-1:0] idx, input logic [DW-1:0] d, input logic err, input int lat);
    dbg_req = 1'b1;
    dbg_idx = idx;
    dbg_q.push_back('{d, err, cyc + 1 + lat});
    @(negedge clk);
    dbg_req = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clr = 1'b0; mon_en = 1'b0; mon_push = 1'b0; mon_wdata = '0;
    dbg_req = 1'b0; dbg_idx = '0;
    repeat (3) @(negedge clk);
    check("rst_sp", 32'(sp), 32'd0);
    check("rst_flags", 32'({ovf, unf, drop}), 32'd0);
    check("rst_pulses", 32'({mon_rvalid, dbg_ack, dbg_err}), 32'd0);
    check("rst_ram", 32'({ram_en, ram_we}), 32'd0);
    check("rst_mon_rdata", mon_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // LIFO order and pop latency
    cmd(1'b1, 32'h100, 1'b0, '0, 0, 0);
    cmd(1'b1, 32'h200, 1'b0, '0, 0, 0);
    cmd(1'b1, 32'h300, 1'b0, '0, 0, 0);
    check("sp_after_3_push", 32'(sp), 32'd3);
    cmd(1'b0, '0, 1'b1, 32'h300, 2, 3);
    cmd(1'b0, '0, 1'b1, 32'h200, 2, 3);
    cmd(1'b0, '0, 1'b1, 32'h100, 2, 3);
    check("sp_after_3_pop", 32'(sp), 32'd0);

    // underflow
    snap = en_cnt;
    cmd(1'b0, '0, 1'b1, 32'h0, 0, 1);
    check("unf_set", 32'(unf), 32'd1);
    check("unf_no_ram", 32'(en_cnt - snap), 32'd0);
    do_clr();
    check("clr_unf", 32'(unf), 32'd0);

    // held mon_en issues one command
    snap = we_cnt;
    mon_en = 1'b1; mon_push = 1'b1; mon_wdata = 32'haaa;
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    check("held_sp", 32'(sp), 32'd1);
    check("held_writes", 32'(we_cnt - snap), 32'd1);

    // overflow on fifth push
    do_clr();
    snap = we_cnt;
    cmd(1'b1, 32'h11, 1'b0, '0, 0, 0);
    cmd(1'b1, 32'h22, 1'b0, '0, 0, 0);
    cmd(1'b1, 32'h33, 1'b0, '0, 0, 0);
    cmd(1'b1, 32'h44, 1'b0, '0, 0, 0);
    check("full_sp", 32'(sp), 32'd4);
    check("full_no_ovf", 32'(ovf), 32'd0);
    cmd(1'b1, 32'h55, 1'b0, '0, 0, 0);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_sp", 32'(sp), 32'd4);
    check("ovf_writes", 32'(we_cnt - snap), 32'd4);
    cmd(1'b0, '0, 1'b1, 32'h44, 2, 3);
    check("ovf_pop_sp", 32'(sp), 32'd3);

    // debug read arriving with a push: push wins, read follows
    do_clr();
    cmd(1'b1, 32'ha, 1'b0, '0, 0, 0);
    cmd(1'b1, 32'hb, 1'b0, '0, 0, 0);
    cmd(1'b1, 32'hc, 1'b0, '0, 0, 0);
    mon_en = 1'b1; mon_push = 1'b1; mon_wdata = 32'hd;
    dbg_req = 1'b1; dbg_idx = 2'd1;
    dbg_q.push_back('{32'hc, 1'b0, cyc + 1 + 3});
    @(negedge clk);
    mon_en = 1'b0;
    @(negedge clk);
    dbg_req = 1'b0;
    repeat (4) @(negedge clk);
    check("dbg_push_sp", 32'(sp), 32'd4);
    dbg(2'd3, 32'ha, 1'b0, 2);
    repeat (3) @(negedge clk);
    do_clr();
    dbg(2'd0, 32'h0, 1'b1, 0);
    repeat (2) @(negedge clk);

    // pending slot: pop parked behind a debug read, push refills slot, third command dropped
    do_clr();
    cmd(1'b1, 32'h5a, 1'b0, '0, 0, 0);
    cmd(1'b1, 32'h5b, 1'b0, '0, 0, 0);
    dbg(2'd0, 32'h5b, 1'b0, 2);
    cmd(1'b0, '0, 1'b1, 32'h5b, 4, 0);
    cmd(1'b1, 32'h5c, 1'b0, '0, 0, 0);
    cmd(1'b0, '0, 1'b0, '0, 0, 0);
    repeat (4) @(negedge clk);
    check("drop_set", 32'(drop), 32'd1);
    check("drop_sp", 32'(sp), 32'd2);
    cmd(1'b0, '0, 1'b1, 32'h5c, 2, 3);
    check("drop_pop_sp", 32'(sp), 32'd1);

    // reset during POP_RD abandons the read
    do_clr();
    cmd(1'b0, '0, 1'b1, 32'h0, 0, 1);
    check("pre_rst_unf", 32'(unf), 32'd1);
    cmd(1'b1, 32'h77, 1'b0, '0, 0, 1);
    snap = rv_cnt;
    mon_en = 1'b1; mon_push = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_no_rvalid", 32'(rv_cnt - snap), 32'd0);
    check("rst_mid_sp", 32'(sp), 32'd0);
    check("rst_mid_flags", 32'({ovf, unf, drop}), 32'd0);

    repeat (8) @(negedge clk);
    check("mon_q_drained", 32'(mon_q.size()), 32'd0);
    check("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
